// File: rtl/pwm_ramp_controller.sv
// rtl/pwm_ramp_controller.sv - duty-cycle ramp sequencer between SPI duty register and PWM peripheral
module pwm_ramp_controller #(
  parameter int IVL_W  = 16,
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              ramp_en,
  input  logic [IVL_W-1:0]  ramp_interval,
  input  logic [DUTY_W-1:0] step_size,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t            r_state;
  logic [IVL_W-1:0]  r_cnt;
  logic [DUTY_W-1:0] r_duty;
  logic              r_busy;
  logic              r_done;

  // Interval 0 and step 0 both behave as 1.
  logic [IVL_W-1:0]  w_ivl_last;
  logic [DUTY_W-1:0] w_eff_step;
  logic              w_tick;
  logic [DUTY_W:0]   w_sum;
  logic [DUTY_W:0]   w_diff;
  logic [DUTY_W-1:0] w_up_next;
  logic [DUTY_W-1:0] w_dn_next;

  assign w_ivl_last = (ramp_interval == '0) ? '0 : (ramp_interval - IVL_W'(1));
  assign w_eff_step = (step_size == '0) ? DUTY_W'(1) : step_size;

  // Using >= means a shortened interval fires on the very next edge.
  assign w_tick = (r_cnt >= w_ivl_last);

  // One extra bit catches overflow/borrow so the step clamps at the target.
  assign w_sum     = {1'b0, r_duty} + {1'b0, w_eff_step};
  assign w_diff    = {1'b0, r_duty} - {1'b0, w_eff_step};
  assign w_up_next = (w_sum > {1'b0, target_duty}) ? target_duty : w_sum[DUTY_W-1:0];
  assign w_dn_next = (w_diff[DUTY_W] || (w_diff[DUTY_W-1:0] < target_duty))
                     ? target_duty : w_diff[DUTY_W-1:0];

  // Ramp state machine; all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_duty  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!ramp_en) begin
        // Pass-through also aborts any ramp in flight without a done pulse.
        r_duty  <= target_duty;
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (target_duty > r_duty) begin
              r_state <= ST_UP;
              r_busy  <= 1'b1;
            end else if (target_duty < r_duty) begin
              r_state <= ST_DOWN;
              r_busy  <= 1'b1;
            end
          end
          ST_UP, ST_DOWN: begin
            if (!w_tick) begin
              r_cnt <= r_cnt + IVL_W'(1);
            end else begin
              r_cnt <= '0;
              // Direction is re-decided at every tick so a moved target reverses the ramp.
              if (target_duty > r_duty) begin
                r_duty <= w_up_next;
                if (w_up_next == target_duty) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ST_UP;
                end
              end else if (target_duty < r_duty) begin
                r_duty <= w_dn_next;
                if (w_dn_next == target_duty) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= ST_DOWN;
                end
              end else begin
                // Target came back to the current duty between ticks.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty_out = r_duty;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// tb/tb_pwm_ramp_controller.sv - self-checking bench for pwm_ramp_controller
module tb_pwm_ramp_controller;

  logic        clk;
  logic        rst_n;
  logic [7:0]  target_duty;
  logic        ramp_en;
  logic [15:0] ramp_interval;
  logic [7:0]  step_size;
  logic [7:0]  duty_out;
  logic        busy;
  logic        done;

  int n_vec;
  int n_err;

  pwm_ramp_controller #(.IVL_W(16), .DUTY_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .target_duty   (target_duty),
    .ramp_en       (ramp_en),
    .ramp_interval (ramp_interval),
    .step_size     (step_size),
    .duty_out      (duty_out),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [7:0]  tgt;
    logic [15:0] ivl;
    logic [7:0]  stp;
    int          ncyc;
    logic [7:0]  e_duty;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  // Reference model: ramp expressed as elapsed edges and clamped arithmetic.
  int m_duty;
  int m_ramping;
  int m_since;
  int m_done;

  task automatic model_edge();
    int ei;
    int es;
    int t;
    ei = (ramp_interval == 0) ? 1 : int'(ramp_interval);
    es = (step_size == 0) ? 1 : int'(step_size);
    t  = int'(target_duty);
    m_done = 0;
    if (!ramp_en) begin
      m_duty    = t;
      m_ramping = 0;
      m_since   = 0;
    end else if (m_ramping == 0) begin
      if (t != m_duty) begin
        m_ramping = 1;
        m_since   = 0;
      end
    end else begin
      m_since++;
      if (m_since >= ei) begin
        m_since = 0;
        if (t > m_duty) m_duty = (m_duty + es > t) ? t : m_duty + es;
        else if (t < m_duty) m_duty = (m_duty - es < t) ? t : m_duty - es;
        if (m_duty == t) begin
          m_ramping = 0;
          m_done    = 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [7:0] tgt, input logic [15:0] ivl, input logic [7:0] stp);
    ramp_en       = en;
    target_duty   = tgt;
    ramp_interval = ivl;
    step_size     = stp;
  endtask

  task automatic add_vec(input logic en, input logic [7:0] tgt, input logic [15:0] ivl, input logic [7:0] stp,
                         input int ncyc, input logic [7:0] ed, input logic eb, input logic edn);
    vec_t v;
    v.en = en; v.tgt = tgt; v.ivl = ivl; v.stp = stp; v.ncyc = ncyc;
    v.e_duty = ed; v.e_busy = eb; v.e_done = edn;
    vecs.push_back(v);
  endtask

  initial begin
    int bound;
    int dones;
    n_vec = 0;
    n_err = 0;

    // Pass-through
    add_vec(1'b0, 8'h80, 16'd4, 8'h10, 1, 8'h80, 1'b0, 1'b0);
    add_vec(1'b0, 8'h00, 16'd4, 8'h10, 1, 8'h00, 1'b0, 1'b0);
    // Basic ramp up 0x00 -> 0x40, interval 4, step 0x10
    add_vec(1'b1, 8'h40, 16'd4, 8'h10, 1, 8'h00, 1'b1, 1'b0);
    add_vec(1'b1, 8'h40, 16'd4, 8'h10, 3, 8'h00, 1'b1, 1'b0);
    add_vec(1'b1, 8'h40, 16'd4, 8'h10, 1, 8'h10, 1'b1, 1'b0);
    add_vec(1'b1, 8'h40, 16'd4, 8'h10, 4, 8'h20, 1'b1, 1'b0);
    add_vec(1'b1, 8'h40, 16'd4, 8'h10, 4, 8'h30, 1'b1, 1'b0);
    add_vec(1'b1, 8'h40, 16'd4, 8'h10, 3, 8'h30, 1'b1, 1'b0);
    add_vec(1'b1, 8'h40, 16'd4, 8'h10, 1, 8'h40, 1'b0, 1'b1);
    add_vec(1'b1, 8'h40, 16'd4, 8'h10, 1, 8'h40, 1'b0, 1'b0);
    // Clamp 0x40 -> 0x45 in one step
    add_vec(1'b1, 8'h45, 16'd4, 8'h10, 1, 8'h40, 1'b1, 1'b0);
    add_vec(1'b1, 8'h45, 16'd4, 8'h10, 4, 8'h45, 1'b0, 1'b1);
    // Clamp 0xF8 -> 0xFF with step 0x0F, no wrap
    add_vec(1'b0, 8'hF8, 16'd1, 8'h0F, 1, 8'hF8, 1'b0, 1'b0);
    add_vec(1'b1, 8'hFF, 16'd1, 8'h0F, 1, 8'hF8, 1'b1, 1'b0);
    add_vec(1'b1, 8'hFF, 16'd1, 8'h0F, 1, 8'hFF, 1'b0, 1'b1);
    // Clamp 0x05 -> 0x00 with step 0x08, no underflow
    add_vec(1'b0, 8'h05, 16'd1, 8'h08, 1, 8'h05, 1'b0, 1'b0);
    add_vec(1'b1, 8'h00, 16'd1, 8'h08, 1, 8'h05, 1'b1, 1'b0);
    add_vec(1'b1, 8'h00, 16'd1, 8'h08, 1, 8'h00, 1'b0, 1'b1);
    // Interval 0 / step 0 -> one LSB per cycle
    add_vec(1'b1, 8'h03, 16'd0, 8'h00, 1, 8'h00, 1'b1, 1'b0);
    add_vec(1'b1, 8'h03, 16'd0, 8'h00, 1, 8'h01, 1'b1, 1'b0);
    add_vec(1'b1, 8'h03, 16'd0, 8'h00, 1, 8'h02, 1'b1, 1'b0);
    add_vec(1'b1, 8'h03, 16'd0, 8'h00, 1, 8'h03, 1'b0, 1'b1);
    add_vec(1'b1, 8'h03, 16'd0, 8'h00, 1, 8'h03, 1'b0, 1'b0);

    drive(1'b0, 8'h00, 16'd1, 8'h01);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("reset_duty", int'(duty_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].tgt, vecs[i].ivl, vecs[i].stp);
      repeat (vecs[i].ncyc) tick();
      check($sformatf("vec%0d_duty", i), int'(duty_out), int'(vecs[i].e_duty));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
    end

    // Reversal: 0x00 -> 0xC0, retarget to 0x10 once 0x30 is reached
    drive(1'b0, 8'h00, 16'd2, 8'h10);
    tick();
    drive(1'b1, 8'hC0, 16'd2, 8'h10);
    bound = 0;
    dones = 0;
    do begin
      tick();
      bound++;
    end while (duty_out != 8'h30 && bound < 50);
    check("rev_reach_30", int'(duty_out), 8'h30);
    target_duty = 8'h10;
    tick();
    check("rev_k1_duty", int'(duty_out), 8'h30);
    dones += int'(done);
    tick();
    check("rev_k2_duty", int'(duty_out), 8'h20);
    check("rev_k2_busy", int'(busy), 1);
    dones += int'(done);
    tick();
    dones += int'(done);
    tick();
    check("rev_k4_duty", int'(duty_out), 8'h10);
    check("rev_k4_busy", int'(busy), 0);
    check("rev_k4_done", int'(done), 1);
    dones += int'(done);
    tick();
    dones += int'(done);
    check("rev_done_count", dones, 1);

    // Abort: drop ramp_en at 0x20 while ramping toward 0x80
    drive(1'b0, 8'h00, 16'd2, 8'h10);
    tick();
    drive(1'b1, 8'h80, 16'd2, 8'h10);
    bound = 0;
    do begin
      tick();
      bound++;
    end while (duty_out != 8'h20 && bound < 50);
    check("abort_reach_20", int'(duty_out), 8'h20);
    ramp_en = 1'b0;
    tick();
    check("abort_duty", int'(duty_out), 8'h80);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    ramp_en = 1'b1;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      dones += int'(done) + int'(busy);
    end
    check("reenable_idle", dones, 0);
    check("reenable_duty", int'(duty_out), 8'h80);

    // Mid-cycle reset with duty_out at 0x55
    drive(1'b0, 8'h55, 16'd1, 8'h01);
    tick();
    check("pre_reset_duty", int'(duty_out), 8'h55);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_duty", int'(duty_out), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the reference model
    drive(1'b0, 8'($urandom), 16'd1, 8'h01);
    model_edge();
    tick();
    check("rand_sync_duty", int'(duty_out), m_duty);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) target_duty = 8'($urandom);
      if ($urandom_range(0, 15) == 0) ramp_interval = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0)
        step_size = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 64));
      ramp_en = ($urandom_range(0, 39) != 0);
      model_edge();
      tick();
      check($sformatf("rand%0d_duty", c), int'(duty_out), m_duty);
      check($sformatf("rand%0d_busy", c), int'(busy), m_ramping);
      check($sformatf("rand%0d_done", c), int'(done), m_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
